// File: rtl/ysyx_mc_ctrl_if.sv
// Control-sequencer bundle: fetch handshake, decoder controls, LSU handshake and core strobes.
// master = sequencer side, slave = datapath/memory side.
interface ysyx_mc_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             if_req;
  logic             if_valid;
  logic [31:0]      if_inst;
  logic [31:0]      ir;
  logic             rf_wr_en;
  logic [2:0]       dm_rd_sel;
  logic [1:0]       dm_wr_sel;
  logic             is_ebreak;
  logic             lsu_req;
  logic             lsu_we;
  logic             lsu_done;
  logic             rf_we;
  logic             pc_we;
  logic             halt;
  logic             bus_err;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output if_req, ir, lsu_req, lsu_we, rf_we, pc_we, halt, bus_err, retire_cnt,
    input  if_valid, if_inst, rf_wr_en, dm_rd_sel, dm_wr_sel, is_ebreak, lsu_done
  );

  modport slave (
    input  if_req, ir, lsu_req, lsu_we, rf_we, pc_we, halt, bus_err, retire_cnt,
    output if_valid, if_inst, rf_wr_en, dm_rd_sel, dm_wr_sel, is_ebreak, lsu_done
  );
endinterface

// File: rtl/ysyx_mc_ctrl.sv
// Multi-cycle NPC control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping, instruction register,
// retire counter, and sticky halt / bus-timeout stop states.
module ysyx_mc_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic           clk,
  input  logic           rst,
  ysyx_mc_ctrl_if.master bus
);
  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic expire_c, store_c, mem_op_c;
  logic if_req_c, lsu_req_c, lsu_we_c, rf_we_c, pc_we_c, halt_c, bus_err_c;

  assign store_c  = (bus.dm_wr_sel != 2'd0);
  assign mem_op_c = store_c || (bus.dm_rd_sel != 3'd0);
  // Expiry fires on the cycle in which the wait count would reach TIMEOUT.
  assign expire_c = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= NOP;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        if (bus.if_valid) begin
          ir_d    = bus.if_inst;
          state_d = DECODE;
        end else if (expire_c) begin
          state_d = ERR;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (bus.is_ebreak) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = HALT;
        end else if (mem_op_c) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (bus.lsu_done)  state_d = WB;
        else if (expire_c) state_d = ERR;
      end
      WB: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    // Counter only runs while parked in a handshake state.
    wait_d = ((state_q == FETCH || state_q == MEM) && state_d == state_q)
             ? wait_q + WAIT_W'(1) : '0;
  end

  always_comb begin
    if_req_c  = 1'b0;
    lsu_req_c = 1'b0;
    lsu_we_c  = 1'b0;
    rf_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    halt_c    = 1'b0;
    bus_err_c = 1'b0;
    unique case (state_q)
      FETCH: if_req_c = 1'b1;
      MEM: begin
        lsu_req_c = 1'b1;
        lsu_we_c  = store_c;
      end
      WB: begin
        rf_we_c = bus.rf_wr_en;
        pc_we_c = 1'b1;
      end
      HALT:    halt_c    = 1'b1;
      ERR:     bus_err_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.if_req     = if_req_c;
  assign bus.lsu_req    = lsu_req_c;
  assign bus.lsu_we     = lsu_we_c;
  assign bus.rf_we      = rf_we_c;
  assign bus.pc_we      = pc_we_c;
  assign bus.halt       = halt_c;
  assign bus.bus_err    = bus_err_c;
  assign bus.ir         = ir_q;
  assign bus.retire_cnt = cnt_q;
endmodule

// File: doc/ysyx_mc_ctrl.md
Name: ysyx_mc_ctrl

Overview:
- Multi-cycle control sequencer for the NPC core.
- Steps each instruction through fetch, decode, execute, memory and writeback, and holds the instruction register that feeds the decoder.
- Uses the decoder's control outputs to choose the path and to gate register-file and PC writes.
- Runs valid/done handshakes with the instruction-fetch and load/store memory ports, and stops the core on ebreak or bus timeout.

Parameters:
- TIMEOUT, 255: maximum wait cycles in FETCH or MEM before bus error. 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- if_req  out  1  instruction fetch request, level.
- if_valid  in  1  fetch data valid.
- if_inst  in  32  fetched instruction.
- ir  out  32  latched instruction, drives the decoder.
- rf_wr_en  in  1  decoder: instruction writes rd.
- dm_rd_sel  in  3  decoder: load type, 0 = none.
- dm_wr_sel  in  2  decoder: store type, 0 = none.
- is_ebreak  in  1  decoder: ebreak.
- lsu_req  out  1  data memory request, level.
- lsu_we  out  1  1 = store, 0 = load; valid while lsu_req.
- lsu_done  in  1  data access complete.
- rf_we  out  1  register-file write strobe.
- pc_we  out  1  PC update strobe.
- halt  out  1  sticky; ebreak retired.
- bus_err  out  1  sticky; handshake timeout.
- retire_cnt  out  CNT_W  retired instruction count.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR. State is held in a register; all outputs except ir and retire_cnt decode combinationally from the state.
- Reset (async, any state) forces:
  - state = IDLE, ir = 32'h00000013 (nop), retire_cnt = 0, wait counter = 0.
  - Consequently if_req, lsu_req, lsu_we, rf_we, pc_we, halt and bus_err are all 0.
- IDLE → FETCH unconditionally on the first clock after reset deasserts.
- FETCH:
  - if_req = 1.
  - On if_valid: ir ← if_inst, → DECODE.
  - Otherwise the wait counter increments. When TIMEOUT ≠ 0 and the counter reaches TIMEOUT, → ERR.
  - if_valid in the same cycle as expiry: if_valid wins.
  - The wait counter clears on leaving FETCH or MEM.
- DECODE: single cycle to let decoder outputs settle from the new ir; → EXEC.
- EXEC: samples the decoder inputs.
  - is_ebreak: retire_cnt += 1, → HALT. No pc_we, no rf_we.
  - Else if dm_wr_sel ≠ 0 or dm_rd_sel ≠ 0: → MEM.
  - Else: → WB.
- MEM:
  - lsu_req = 1; lsu_we = (dm_wr_sel ≠ 0). If both selectors are nonzero, the store wins.
  - Decoder inputs must stay stable, since ir does not change.
  - On lsu_done: → WB.
  - Timeout behaves as in FETCH, and lsu_done beats simultaneous expiry.
- WB:
  - rf_we = rf_wr_en, pc_we = 1, each for exactly one cycle.
  - retire_cnt += 1, wrapping modulo 2^CNT_W.
  - → FETCH.
- HALT: halt = 1, no requests; remains until reset.
- ERR: bus_err = 1, no requests, no strobes; remains until reset.
- Unsolicited handshakes: if_valid outside FETCH and lsu_done outside MEM are ignored. They never change ir or state.
- Latency:
  - Non-memory instruction with if_valid in its first FETCH cycle: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Memory instruction with zero-wait lsu_done: 5 cycles.
  - Each wait cycle adds 1.
- rf_we and pc_we never assert outside WB. if_req and lsu_req are never high in the same cycle.
- Reset mid-MEM or mid-FETCH drops the request immediately (asynchronous). The in-flight instruction is not retired.

Test Plan:
- Reset release, then addi (0x00100093) with if_valid held high → if_req high 1 cycle after reset release; ir = 0x00100093; rf_we and pc_we pulse in the 4th cycle of the instruction; retire_cnt = 1.
- Store sw (0x00112023, dm_wr_sel = 3) with lsu_done delayed 3 cycles → lsu_req high 4 cycles with lsu_we = 1; rf_we = 0 and pc_we = 1 in WB; total 8 cycles.
- Load lw (dm_rd_sel = 5) with lsu_done immediate → lsu_we = 0 for 1 cycle; rf_we = 1 in WB; total 5 cycles.
- ebreak (0x00100073) after 2 retired instructions → halt = 1 on the cycle after EXEC; retire_cnt = 3; no further if_req over 20 idle cycles.
- TIMEOUT = 4, if_valid held 0 → ERR entered after 4 FETCH cycles; bus_err = 1, if_req = 0. A late if_valid is ignored. Separately, if_valid arriving exactly on the 4th FETCH cycle proceeds normally to DECODE.
- rst asserted mid-MEM with lsu_req = 1 → lsu_req drops without waiting for a clock edge; retire_cnt = 0, ir = 0x00000013; after release, fetch restarts through IDLE → FETCH.
